matrix_mac_engine: RTL and testbench
====================================

// Module: matrix_mac_engine
// PURPOSE
//  Consumer stage directly downstream of the matrix reader. Captures the streamed A (a1 x a2)
//  and B (a2 x a3) elements into local register arrays and computes C = A*B with one MAC per cycle.
//  Emits C in row-major order on a valid/ready stream.
// PARAMETERS
//  DW    32  element / result data width
//  MAXD   8  maximum supported dimension; arrays are MAXD x MAXD, dims legal in 1..MAXD
// PORTS
//  clk        in   1   clock
//  reset_n    in   1   synchronous, active-low reset
//  a1,a2,a3   in   5   dims: A is a1 x a2, B is a2 x a3; stable from read_done until done
//  row,col    in   4   element coordinates of data
//  data       in   DW  element value
//  readA      in   1   high: write data to A[row][col]
//  readB      in   1   high: write data to B[row][col]
//  read_done  in   1   one-cycle pulse; all elements have been delivered
//  c_valid    out  1   result element available
//  c_ready    in   1   downstream accepts result
//  c_row      out  4   result row index i
//  c_col      out  4   result column index j
//  c_data     out  DW  C[i][j]
//  busy       out  1   high in CALC or OUT
//  done       out  1   one-cycle pulse after the last result handshake, or on error
//  err        out  1   sticky; illegal dims seen at read_done; cleared by reset or next read_done
// BEHAVIOUR
//  Reset: state=IDLE; c_valid, c_row, c_col, c_data, busy, done and err are 0; i/j/k/acc are 0.
//   Arrays are not reset.
//  States:
//   - IDLE: accepts loads. readA/readB high writes the addressed location every cycle.
//     Repeated writes of the same element are idempotent, because the reader holds
//     readA/readB high between elements.
//   - On read_done in IDLE: latch dims. If any dim is 0 or greater than MAXD: err=1, go to DONE.
//     Otherwise clear err, set i=j=k=0 and acc=0, go to CALC.
//   - CALC: each cycle acc <= acc + A[i][k]*B[k][j] and k++. On the cycle k==a2-1, the final sum
//     is registered into c_data with c_row=i, c_col=j and c_valid=1, then go to OUT.
//     Latency: a2 cycles per element, measured from CALC entry to c_valid.
//   - OUT: c_valid and all c_* outputs are held stable until c_valid&&c_ready. On the handshake:
//     c_valid=0, then advance j. If j==a3-1, set j=0 and i++. If the last element
//     (i==a1-1, j==a3-1) was taken, go to DONE; otherwise set k=0, acc=0 and go to CALC.
//   - DONE: done=1 for one cycle, then return to IDLE.
//  Boundaries:
//   - Loads with row or col >= MAXD are dropped.
//   - readA and readB both high in the same cycle: both arrays are written.
//   - Loads during CALC/OUT are ignored, so the arrays stay frozen while computing.
//   - read_done outside IDLE is ignored.
//   - c_ready may be high before c_valid; no combinational path exists from c_ready to c_valid.
//   - Reset mid-operation aborts immediately to IDLE. No done pulse is issued, and partial
//     results are discarded.
//  Arithmetic:
//   - Operands are unsigned.
//   - Each product is 2*DW bits; the accumulator is 2*DW bits and wraps modulo 2^(2*DW).
//   - Without the optional feature, c_data is acc[DW-1:0] (truncation).
// CONFIGURATION
//  MATMUL_SAT_EN defined:
//   - If the final acc exceeds 2^DW-1, c_data = {DW{1'b1}} (saturation).
//   - An extra output port ovf (1 bit, sticky) is added; it is cleared by reset or the next
//     read_done.
//  MATMUL_SAT_EN undefined: truncation only; no ovf port.
// TESTING
//  1. A=[1 2;3 4], B=I2, a1=a2=a3=2, c_ready=1 -> C=(0,0)1,(0,1)2,(1,0)3,(1,1)4; c_valid every 3 cycles; done once.
//  2. Dot product: a1=1, a2=3, a3=1, A=[1 2 3], B=[4;5;6] -> single result (0,0)=32, c_valid 3 cycles after CALC entry.
//  3. Backpressure: test 1 with c_ready low 5 cycles per element -> c_* held stable, order unchanged, no loss.
//  4. Illegal dims: a2=0, pulse read_done -> err=1, done pulse, no c_valid. Then legal dims -> err clears.
//  5. Overflow: a1=a2=a3=1, A=B=32'h0001_0000 -> c_data=0 (truncate); with MATMUL_SAT_EN: 32'hFFFF_FFFF, ovf=1.
//  6. Reset mid-CALC of a 4x4 job -> all outputs 0 next cycle, state IDLE; a new job computes correctly.

Source files
------------

// File: rtl/matrix_mac_engine.sv
// Captures streamed A/B matrices and computes C = A*B with one MAC per cycle, emitting C row-major.
// Optional MATMUL_SAT_EN: saturate results wider than DW and expose a sticky ovf flag.
module matrix_mac_engine #(
    parameter int DW   = 32,
    parameter int MAXD = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [4:0]    a1,
    input  logic [4:0]    a2,
    input  logic [4:0]    a3,
    input  logic [3:0]    row,
    input  logic [3:0]    col,
    input  logic [DW-1:0] data,
    input  logic          readA,
    input  logic          readB,
    input  logic          read_done,
    output logic          c_valid,
    input  logic          c_ready,
    output logic [3:0]    c_row,
    output logic [3:0]    c_col,
    output logic [DW-1:0] c_data,
    output logic          busy,
    output logic          done,
`ifdef MATMUL_SAT_EN
    output logic          ovf,
`endif
    output logic          err
);

    localparam int IW = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int AW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] a_mem [MAXD][MAXD];
    logic [DW-1:0] b_mem [MAXD][MAXD];

    logic [4:0]    a1_q, a2_q, a3_q;
    logic [IW-1:0] i_q, j_q, k_q;
    logic [AW-1:0] acc_q, prod, acc_sum;
    logic [DW-1:0] result;
    logic          dims_ok, load_ok, last_k, last_j, last_i, handshake;

    assign dims_ok = (a1 != 5'd0) && (int'(a1) <= MAXD) &&
                     (a2 != 5'd0) && (int'(a2) <= MAXD) &&
                     (a3 != 5'd0) && (int'(a3) <= MAXD);
    assign load_ok = (state_q == IDLE) && (int'(row) < MAXD) && (int'(col) < MAXD);

    assign prod      = AW'(a_mem[i_q][k_q]) * AW'(b_mem[k_q][j_q]);
    assign acc_sum   = acc_q + prod;
    assign last_k    = (5'(k_q) == a2_q - 5'd1);
    assign last_j    = (5'(j_q) == a3_q - 5'd1);
    assign last_i    = (5'(i_q) == a1_q - 5'd1);
    assign handshake = c_valid && c_ready;

`ifdef MATMUL_SAT_EN
    assign result = (acc_sum[AW-1:DW] != '0) ? {DW{1'b1}} : acc_sum[DW-1:0];
`else
    assign result = acc_sum[DW-1:0];
`endif

    // Operand storage has no reset; writes are only honoured while idle so a job sees frozen data.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            if (readA) a_mem[row[IW-1:0]][col[IW-1:0]] <= data;
            if (readB) b_mem[row[IW-1:0]][col[IW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (read_done) state_d = dims_ok ? CALC : DONE;
            CALC: begin
                busy = 1'b1;
                if (last_k) state_d = OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (handshake) state_d = (last_i && last_j) ? DONE : CALC;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Index counters, accumulator and the registered result stream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            c_valid <= 1'b0;
            c_row   <= '0;
            c_col   <= '0;
            c_data  <= '0;
            err     <= 1'b0;
`ifdef MATMUL_SAT_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_done) begin
                        a1_q <= a1;
                        a2_q <= a2;
                        a3_q <= a3;
`ifdef MATMUL_SAT_EN
                        ovf  <= 1'b0;
`endif
                        if (!dims_ok) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            i_q   <= '0;
                            j_q   <= '0;
                            k_q   <= '0;
                            acc_q <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_sum;
                    k_q   <= k_q + 1'b1;
                    if (last_k) begin
                        c_data  <= result;
                        c_row   <= 4'(i_q);
                        c_col   <= 4'(j_q);
                        c_valid <= 1'b1;
`ifdef MATMUL_SAT_EN
                        if (acc_sum[AW-1:DW] != '0) ovf <= 1'b1;
`endif
                    end
                end
                OUT: begin
                    if (handshake) begin
                        c_valid <= 1'b0;
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                        if (!(last_i && last_j)) begin
                            k_q   <= '0;
                            acc_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed self-checking bench for matrix_mac_engine: reset, identity, dot product,
// backpressure, illegal dims, overflow and reset abort. Honours MATMUL_SAT_EN if defined.
module tb_matrix_mac_engine;

    logic        clk;
    logic        reset_n;
    logic [4:0]  a1, a2, a3;
    logic [3:0]  row, col;
    logic [31:0] data;
    logic        readA, readB, read_done;
    logic        c_valid, c_ready;
    logic [3:0]  c_row, c_col;
    logic [31:0] c_data;
    logic        busy, done, err;
`ifdef MATMUL_SAT_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    matrix_mac_engine #(.DW(32), .MAXD(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .row       (row),
        .col       (col),
        .data      (data),
        .readA     (readA),
        .readB     (readB),
        .read_done (read_done),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c_row     (c_row),
        .c_col     (c_col),
        .c_data    (c_data),
        .busy      (busy),
        .done      (done),
`ifdef MATMUL_SAT_EN
        .ovf       (ovf),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle load; called and returns just after a falling edge.
    task automatic load(input logic wa, input logic wb, input logic [3:0] r, input logic [3:0] c,
                        input logic [31:0] v);
        readA = wa; readB = wb; row = r; col = c; data = v;
        @(negedge clk);
        readA = 1'b0; readB = 1'b0;
    endtask

    task automatic start_job(input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] d3);
        a1 = d1; a2 = d2; a3 = d3;
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_valid, busy, done, err} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {c_valid, busy, done, err});
        end
        checks++;
        if ({c_row, c_col, c_data} !== 40'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0", {c_row, c_col, c_data});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity;
        logic [31:0] exp_d [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        logic [3:0]  exp_r [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
        logic [3:0]  exp_c [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        int cnt;
        load(1, 0, 0, 0, 1); load(1, 0, 0, 1, 2); load(1, 0, 1, 0, 3); load(1, 0, 1, 1, 4);
        load(0, 1, 0, 0, 1); load(0, 1, 0, 1, 0); load(0, 1, 1, 0, 0); load(0, 1, 1, 1, 1);
        c_ready = 1'b1;
        start_job(2, 2, 2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ident_busy: got %b expected 1", busy);
        end
        cnt = 0;
        for (int e = 0; e < 4; e++) begin
            while (c_valid !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt !== ((e == 0) ? 2 : 3)) begin
                failures++;
                $display("[TB] FAIL ident_latency%0d: got %0d expected %0d", e, cnt, (e == 0) ? 2 : 3);
            end
            checks++;
            if ({c_row, c_col, c_data} !== {exp_r[e], exp_c[e], exp_d[e]}) begin
                failures++;
                $display("[TB] FAIL ident_elem%0d: got (%0d,%0d)%0d expected (%0d,%0d)%0d",
                         e, c_row, c_col, c_data, exp_r[e], exp_c[e], exp_d[e]);
            end
            @(negedge clk);
            cnt = 1;
        end
        checks++;
        if ({done, c_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ident_done: got done/valid %b expected 10", {done, c_valid});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL ident_idle: got done/busy %b expected 00", {done, busy});
        end
    endtask

    task automatic test_dot_product;
        int cnt;
        load(1, 0, 0, 0, 1); load(1, 0, 0, 1, 2); load(1, 0, 0, 2, 3);
        load(0, 1, 0, 0, 4); load(0, 1, 1, 0, 5); load(0, 1, 2, 0, 6);
        c_ready = 1'b1;
        start_job(1, 3, 1);
        load(1, 0, 0, 0, 100);
        cnt = 1;
        while (c_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 3) begin
            failures++;
            $display("[TB] FAIL dot_latency: got %0d expected 3", cnt);
        end
        checks++;
        if ({c_row, c_col, c_data} !== {4'd0, 4'd0, 32'd32}) begin
            failures++;
            $display("[TB] FAIL dot_value: got (%0d,%0d)%0d expected (0,0)32", c_row, c_col, c_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dot_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_d [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        logic [3:0]  exp_r [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
        logic [3:0]  exp_c [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic stable;
        int cnt;
        load(1, 0, 0, 0, 1); load(1, 0, 0, 1, 2); load(1, 0, 1, 0, 3); load(1, 0, 1, 1, 4);
        load(0, 1, 0, 0, 1); load(0, 1, 0, 1, 0); load(0, 1, 1, 0, 0); load(0, 1, 1, 1, 1);
        c_ready = 1'b0;
        start_job(2, 2, 2);
        cnt = 0;
        for (int e = 0; e < 4; e++) begin
            while (c_valid !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt !== ((e == 0) ? 2 : 3)) begin
                failures++;
                $display("[TB] FAIL bp_latency%0d: got %0d expected %0d", e, cnt, (e == 0) ? 2 : 3);
            end
            stable = 1'b1;
            for (int s = 0; s < 5; s++) begin
                if ({c_valid, c_row, c_col, c_data} !== {1'b1, exp_r[e], exp_c[e], exp_d[e]})
                    stable = 1'b0;
                read_done = (s == 2);
                @(negedge clk);
            end
            read_done = 1'b0;
            checks++;
            if (!stable || {c_valid, c_row, c_col, c_data} !== {1'b1, exp_r[e], exp_c[e], exp_d[e]}) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: got (%0d,%0d)%0d valid %b expected (%0d,%0d)%0d held",
                         e, c_row, c_col, c_data, c_valid, exp_r[e], exp_c[e], exp_d[e]);
            end
            c_ready = 1'b1;
            @(negedge clk);
            c_ready = 1'b0;
            checks++;
            if ({c_valid, done} !== {1'b0, (e == 3) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("[TB] FAIL bp_take%0d: got valid/done %b expected %b", e, {c_valid, done},
                         {1'b0, (e == 3) ? 1'b1 : 1'b0});
            end
            cnt = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_illegal_dims;
        int cnt;
        c_ready = 1'b1;
        start_job(2, 0, 2);
        checks++;
        if ({err, done, c_valid, busy} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL illegal_flags: got err/done/valid/busy %b expected 1100",
                     {err, done, c_valid, busy});
        end
        @(negedge clk);
        checks++;
        if ({err, done} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL illegal_sticky: got err/done %b expected 10", {err, done});
        end
        load(1, 0, 0, 0, 7); load(0, 1, 0, 0, 6); load(1, 0, 8, 0, 99);
        start_job(1, 1, 1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_clear: got err %b expected 0", err);
        end
        cnt = 0;
        while (c_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if ({cnt == 1, c_data} !== {1'b1, 32'd42}) begin
            failures++;
            $display("[TB] FAIL drop_oob: got %0d after %0d cycles expected 42 after 1", c_data, cnt);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int cnt;
        logic [31:0] exp_v;
`ifdef MATMUL_SAT_EN
        exp_v = 32'hFFFF_FFFF;
`else
        exp_v = 32'h0;
`endif
        c_ready = 1'b1;
        load(1, 1, 0, 0, 32'h0001_0000);
        start_job(1, 1, 1);
        cnt = 0;
        while (c_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (c_data !== exp_v) begin
            failures++;
            $display("[TB] FAIL ovf_value: got %h expected %h", c_data, exp_v);
        end
        @(negedge clk);
`ifdef MATMUL_SAT_EN
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_flag: got %b expected 1", ovf);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc;
        int cnt;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1, 0, 4'(r), 4'(c), 32'(r * 4 + c + 1));
                load(0, 1, 4'(r), 4'(c), 32'(c + 1));
            end
        c_ready = 1'b1;
        start_job(4, 4, 4);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({c_valid, busy, done, err, c_row, c_col, c_data} !== 44'h0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got %h expected 0",
                     {c_valid, busy, done, err, c_row, c_col, c_data});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL abort_idle: got busy/done %b expected 00", {busy, done});
        end
        start_job(1, 4, 4);
`ifdef MATMUL_SAT_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear: got %b expected 0", ovf);
        end
`endif
        cnt = 0;
        for (int e = 0; e < 4; e++) begin
            while (c_valid !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if ({cnt == ((e == 0) ? 4 : 5), c_row, c_col, c_data} !==
                {1'b1, 4'd0, 4'(e), 32'(10 * (e + 1))}) begin
                failures++;
                $display("[TB] FAIL rerun_elem%0d: got (%0d,%0d)%0d after %0d expected (0,%0d)%0d",
                         e, c_row, c_col, c_data, cnt, e, 10 * (e + 1));
            end
            @(negedge clk);
            cnt = 1;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rerun_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; a1 = '0; a2 = '0; a3 = '0; row = '0; col = '0; data = '0;
        readA = 1'b0; readB = 1'b0; read_done = 1'b0; c_ready = 1'b0;
        test_reset();
        test_identity();
        test_dot_product();
        test_backpressure();
        test_illegal_dims();
        test_overflow();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
